ex_issue_stage: RTL and testbench
=================================

// Module: ex_issue_stage
// PURPOSE
//  ID->EX pipeline register of the RV32I core; drives the combinational alu one cycle after issue.
//  Forwards operands from EX and WB and selects A/B sources, presenting a_val/b_val/alu_sel to alu.
//  Detects load-use hazards and inserts one bubble per hazard.
//  Honours downstream hold and branch flush, and counts inserted bubbles.
// PARAMETERS
//  CNT_W  32  width of bubble performance counter (saturating)
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  id_valid       in   1   decode presents an instruction
//  id_ready       out  1   issue accepted this cycle (id_valid & id_ready)
//  id_pc          in   32  instruction PC
//  id_rs1_idx     in   5   source register 1 index
//  id_rs2_idx     in   5   source register 2 index
//  id_rd_idx      in   5   destination register index
//  id_uses_rs1    in   1   instruction reads rs1
//  id_uses_rs2    in   1   instruction reads rs2 (incl. store data)
//  id_rs1_data    in   32  regfile read data, rs1
//  id_rs2_data    in   32  regfile read data, rs2
//  id_imm         in   32  sign-extended immediate
//  id_alu_sel     in   4   ALU op code, ALU_* encoding
//  id_a_sel       in   1   0=rs1, 1=pc
//  id_b_sel       in   1   0=rs2, 1=imm
//  id_reg_wen     in   1   instruction writes rd
//  id_is_load     in   1   instruction is a load
//  ex_alu_out     in   32  alu out_val for the instruction now in EX
//  wb_valid       in   1   WB stage holds a valid instruction
//  wb_reg_wen     in   1   WB instruction writes rd
//  wb_rd_idx      in   5   WB destination index
//  wb_data        in   32  WB writeback value (load data or ALU result)
//  ex_hold        in   1   downstream busy; freeze EX register
//  ex_flush       in   1   kill instruction being issued (branch taken in EX)
//  ex_valid       out  1   EX register valid
//  ex_pc          out  32  registered PC
//  ex_a_val       out  32  to alu a_val
//  ex_b_val       out  32  to alu b_val
//  ex_alu_sel     out  4   to alu alu_sel
//  ex_rs2_val     out  32  forwarded rs2 (store data)
//  ex_rd_idx      out  5   registered rd
//  ex_reg_wen     out  1   registered rd write enable
//  ex_is_load     out  1   registered load flag
//  bubble_count   out  CNT_W  load-use bubbles inserted since reset
// BEHAVIOUR
//  - Reset: every output register 0 (ex_valid=0, ex_alu_sel=0, data 0), bubble_count=0.
//  - Latency: accepted instruction appears on ex_* the next cycle; alu result is combinational after.
//  - Forward per source (rs1, rs2), idx!=0 only. Priority:
//    1) ex_valid & ex_reg_wen & !ex_is_load & ex_rd_idx==idx -> ex_alu_out;
//    2) wb_valid & wb_reg_wen & wb_rd_idx==idx -> wb_data;
//    3) regfile data.
//    idx==0 always uses regfile data (hardwired 0).
//  - ex_a_val = a_sel ? id_pc : fwd_rs1; ex_b_val = b_sel ? id_imm : fwd_rs2; ex_rs2_val = fwd_rs2.
//  - Load-use hazard = id_valid & ex_valid & ex_is_load & ex_reg_wen & ex_rd_idx!=0 &
//    ((id_uses_rs1 & rs1==ex_rd_idx) | (id_uses_rs2 & rs2==ex_rd_idx)).
//  - id_ready = !ex_hold & !hazard.
//  - Per-cycle update, highest priority first:
//    1) ex_hold: all EX regs unchanged; flush ignored (branch unit keeps flush high until hold drops).
//    2) ex_flush: ex_valid<=0, other fields don't-care; ID instruction discarded; no count.
//    3) hazard: bubble, ex_valid<=0, bubble_count+=1 (saturate at all-ones).
//    4) id_valid: load all fields, ex_valid<=1.
//    5) otherwise: ex_valid<=0.
//  - After a bubble the load sits in WB, so the retried instruction takes wb_data; max one bubble per hazard.
//  - Reset mid-operation: in-flight EX instruction dropped, no partial state survives.
// STRUCTURE
//  - Shared header ex_ctrl.vh: A_SEL_RS1/A_SEL_PC, B_SEL_RS2/B_SEL_IMM; alu ops via existing ALU_* header.
//  - One sub-module: operand_fwd_mux (idx, regfile data, EX/WB match info -> value), instanced for rs1 and rs2.
//  - Hazard detect and update-priority logic inline.
// TESTING
//  - addi x1,x0,5 then add x2,x1,x1 back-to-back, ex_alu_out=5 -> ex_a_val=ex_b_val=5, no bubble.
//  - lw x3 then add x4,x3,x0 -> id_ready=0 one cycle, ex_valid=0, bubble_count=1;
//    retry with wb_data=0xDEADBEEF -> ex_a_val=0xDEADBEEF.
//  - EX rd=x5 (0x11) and WB rd=x5 (0x22) both match, consumer rs1=x5 -> ex_a_val=0x11.
//  - Producer rd=x0 with ex_alu_out=0x1234, consumer rs1=x0, id_rs1_data=0 -> ex_a_val=0.
//  - ex_hold=1 for 3 cycles with ex_flush=1 -> ex_* stable, id_ready=0;
//    hold drops, flush still high -> ex_valid=0 next cycle.
//  - rst asserted while ex_valid=1 and bubble_count=7 -> next cycle ex_valid=0, all outputs 0.

Source files
------------

// File: rtl/ex_issue_stage_pkg.sv
// Shared types and constants for the ID->EX issue stage: operand select codes,
// ALU op encoding, the EX register payload and the per-cycle update action.
package ex_issue_stage_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int ALU_SEL_W = 4;

    localparam logic A_SEL_RS1 = 1'b0;
    localparam logic A_SEL_PC  = 1'b1;
    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    // What the EX register does on the coming edge, highest priority first.
    typedef enum logic [2:0] {
        UPD_HOLD   = 3'd0,
        UPD_FLUSH  = 3'd1,
        UPD_BUBBLE = 3'd2,
        UPD_ISSUE  = 3'd3,
        UPD_IDLE   = 3'd4
    } upd_e;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      a_val;
        logic [XLEN-1:0]      b_val;
        logic [ALU_SEL_W-1:0] alu_sel;
        logic [XLEN-1:0]      rs2_val;
        logic [REG_IDX_W-1:0] rd_idx;
        logic                 reg_wen;
        logic                 is_load;
    } ex_reg_t;

    // x0 never matches a producer: it is hardwired to zero.
    function automatic logic reg_hit(input logic en,
                                     input logic [REG_IDX_W-1:0] src_idx,
                                     input logic [REG_IDX_W-1:0] dst_idx);
        return en && (src_idx == dst_idx) && (src_idx != '0);
    endfunction

endpackage

// File: rtl/ex_issue_stage_if.sv
// Signal bundle between decode/WB/branch logic and the issue stage.
// Handshake: an instruction is issued on a rising edge where id_valid & id_ready are both high.
interface ex_issue_stage_if #(parameter int CNT_W = 32) ();
    import ex_issue_stage_pkg::*;

    logic                 id_valid;
    logic                 id_ready;
    logic [XLEN-1:0]      id_pc;
    logic [REG_IDX_W-1:0] id_rs1_idx;
    logic [REG_IDX_W-1:0] id_rs2_idx;
    logic [REG_IDX_W-1:0] id_rd_idx;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [XLEN-1:0]      id_rs1_data;
    logic [XLEN-1:0]      id_rs2_data;
    logic [XLEN-1:0]      id_imm;
    logic [ALU_SEL_W-1:0] id_alu_sel;
    logic                 id_a_sel;
    logic                 id_b_sel;
    logic                 id_reg_wen;
    logic                 id_is_load;
    logic [XLEN-1:0]      ex_alu_out;
    logic                 wb_valid;
    logic                 wb_reg_wen;
    logic [REG_IDX_W-1:0] wb_rd_idx;
    logic [XLEN-1:0]      wb_data;
    logic                 ex_hold;
    logic                 ex_flush;
    logic                 ex_valid;
    logic [XLEN-1:0]      ex_pc;
    logic [XLEN-1:0]      ex_a_val;
    logic [XLEN-1:0]      ex_b_val;
    logic [ALU_SEL_W-1:0] ex_alu_sel;
    logic [XLEN-1:0]      ex_rs2_val;
    logic [REG_IDX_W-1:0] ex_rd_idx;
    logic                 ex_reg_wen;
    logic                 ex_is_load;
    logic [CNT_W-1:0]     bubble_count;

    modport slave (
        input  id_valid, id_pc, id_rs1_idx, id_rs2_idx, id_rd_idx,
               id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data, id_imm,
               id_alu_sel, id_a_sel, id_b_sel, id_reg_wen, id_is_load,
               ex_alu_out, wb_valid, wb_reg_wen, wb_rd_idx, wb_data,
               ex_hold, ex_flush,
        output id_ready, ex_valid, ex_pc, ex_a_val, ex_b_val, ex_alu_sel,
               ex_rs2_val, ex_rd_idx, ex_reg_wen, ex_is_load, bubble_count
    );

    modport master (
        output id_valid, id_pc, id_rs1_idx, id_rs2_idx, id_rd_idx,
               id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data, id_imm,
               id_alu_sel, id_a_sel, id_b_sel, id_reg_wen, id_is_load,
               ex_alu_out, wb_valid, wb_reg_wen, wb_rd_idx, wb_data,
               ex_hold, ex_flush,
        input  id_ready, ex_valid, ex_pc, ex_a_val, ex_b_val, ex_alu_sel,
               ex_rs2_val, ex_rd_idx, ex_reg_wen, ex_is_load, bubble_count
    );

endinterface

// File: rtl/ex_issue_stage_fwd_mux.sv
// Operand forwarding mux for one source register: EX result beats WB value beats regfile.
module operand_fwd_mux
    import ex_issue_stage_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx_i,
    input  logic [XLEN-1:0]      rf_data_i,
    input  logic                 ex_fwd_en_i,
    input  logic [REG_IDX_W-1:0] ex_rd_idx_i,
    input  logic [XLEN-1:0]      ex_data_i,
    input  logic                 wb_fwd_en_i,
    input  logic [REG_IDX_W-1:0] wb_rd_idx_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic [XLEN-1:0]      val_o
);

    always_comb begin
        val_o = rf_data_i;
        if (reg_hit(ex_fwd_en_i, idx_i, ex_rd_idx_i)) begin
            val_o = ex_data_i;
        end else if (reg_hit(wb_fwd_en_i, idx_i, wb_rd_idx_i)) begin
            val_o = wb_data_i;
        end
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID->EX pipeline register: forwards operands, stalls one cycle on load-use,
// honours hold/flush and counts inserted bubbles (saturating).
module ex_issue_stage
    import ex_issue_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    ex_issue_stage_if.slave io
);

    ex_reg_t          ex_q, ex_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    upd_e             upd;
    logic             ex_fwd_en;
    logic             wb_fwd_en;
    logic             hazard;
    logic [XLEN-1:0]  rs1_fwd;
    logic [XLEN-1:0]  rs2_fwd;

    // A load in EX has no data yet, so it can never be an EX-stage forwarding source.
    assign ex_fwd_en = valid_q & ex_q.reg_wen & ~ex_q.is_load;
    assign wb_fwd_en = io.wb_valid & io.wb_reg_wen;

    operand_fwd_mux u_fwd_rs1 (
        .idx_i       (io.id_rs1_idx),
        .rf_data_i   (io.id_rs1_data),
        .ex_fwd_en_i (ex_fwd_en),
        .ex_rd_idx_i (ex_q.rd_idx),
        .ex_data_i   (io.ex_alu_out),
        .wb_fwd_en_i (wb_fwd_en),
        .wb_rd_idx_i (io.wb_rd_idx),
        .wb_data_i   (io.wb_data),
        .val_o       (rs1_fwd)
    );

    operand_fwd_mux u_fwd_rs2 (
        .idx_i       (io.id_rs2_idx),
        .rf_data_i   (io.id_rs2_data),
        .ex_fwd_en_i (ex_fwd_en),
        .ex_rd_idx_i (ex_q.rd_idx),
        .ex_data_i   (io.ex_alu_out),
        .wb_fwd_en_i (wb_fwd_en),
        .wb_rd_idx_i (io.wb_rd_idx),
        .wb_data_i   (io.wb_data),
        .val_o       (rs2_fwd)
    );

    always_comb begin
        logic ld_en;
        ld_en  = valid_q & ex_q.is_load & ex_q.reg_wen;
        hazard = io.id_valid &
                 ((io.id_uses_rs1 & reg_hit(ld_en, io.id_rs1_idx, ex_q.rd_idx)) |
                  (io.id_uses_rs2 & reg_hit(ld_en, io.id_rs2_idx, ex_q.rd_idx)));
    end

    assign io.id_ready = ~io.ex_hold & ~hazard;

    always_comb begin
        upd = UPD_IDLE;
        if (io.ex_hold) begin
            upd = UPD_HOLD;
        end else if (io.ex_flush) begin
            upd = UPD_FLUSH;
        end else if (hazard) begin
            upd = UPD_BUBBLE;
        end else if (io.id_valid) begin
            upd = UPD_ISSUE;
        end
    end

    // Payload fields are left as-is on flush/bubble; only valid matters then.
    always_comb begin
        ex_d    = ex_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (upd)
            UPD_HOLD: begin
                valid_d = valid_q;
            end
            UPD_FLUSH: begin
                valid_d = 1'b0;
            end
            UPD_BUBBLE: begin
                valid_d = 1'b0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UPD_ISSUE: begin
                valid_d         = 1'b1;
                ex_d.pc         = io.id_pc;
                ex_d.a_val      = (io.id_a_sel == A_SEL_PC) ? io.id_pc : rs1_fwd;
                ex_d.b_val      = (io.id_b_sel == B_SEL_IMM) ? io.id_imm : rs2_fwd;
                ex_d.alu_sel    = io.id_alu_sel;
                ex_d.rs2_val    = rs2_fwd;
                ex_d.rd_idx     = io.id_rd_idx;
                ex_d.reg_wen    = io.id_reg_wen;
                ex_d.is_load    = io.id_is_load;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io.ex_valid     = valid_q;
    assign io.ex_pc        = ex_q.pc;
    assign io.ex_a_val     = ex_q.a_val;
    assign io.ex_b_val     = ex_q.b_val;
    assign io.ex_alu_sel   = ex_q.alu_sel;
    assign io.ex_rs2_val   = ex_q.rs2_val;
    assign io.ex_rd_idx    = ex_q.rd_idx;
    assign io.ex_reg_wen   = ex_q.reg_wen;
    assign io.ex_is_load   = ex_q.is_load;
    assign io.bubble_count = cnt_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed pipeline scenarios plus random traffic,
// scored against a cycle-level reference model of the EX slot.
module tb_ex_issue_stage;
    import ex_issue_stage_pkg::*;

    localparam int CNT_W = 4;
    localparam int EXP_W = 139;
    localparam int CHK_W = 160;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ex_issue_stage_if #(.CNT_W(CNT_W)) io ();

    ex_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        id_valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] d1, d2, imm;
        logic [3:0]  alu;
        logic        a_sel, b_sel, wen, load;
        logic [31:0] alu_out;
        logic        wb_valid, wb_wen;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        hold, flush;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc, a, b;
        logic [3:0]  alu;
        logic [31:0] rs2v;
        logic [4:0]  rd;
        logic        wen, load;
    } mex_t;

    mex_t        m;
    int unsigned m_cnt;
    logic [EXP_W-1:0] exp_q[$];
    logic [CNT_W:0]   stat_q[$];

    task automatic chk(input string name, input logic [CHK_W-1:0] got, input logic [CHK_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic a_sel, input logic b_sel,
                                 input logic [31:0] imm, input logic wen, input logic load);
        stim_t s;
        s = idle_stim();
        s.id_valid = 1'b1;
        s.pc = $urandom() & 32'hFFFF_FFFC;
        s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
        s.d1 = $urandom(); s.d2 = $urandom(); s.imm = imm;
        s.alu = 4'($urandom_range(0, 10));
        s.a_sel = a_sel; s.b_sel = b_sel; s.wen = wen; s.load = load;
        s.alu_out = $urandom();
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom(),
               1'($urandom), ($urandom_range(0, 3) == 0));
        s.id_valid = ($urandom_range(0, 3) != 0);
        s.wb_valid = 1'($urandom); s.wb_wen = 1'($urandom);
        s.wb_rd = 5'($urandom_range(0, 3)); s.wb_data = $urandom();
        s.hold = ($urandom_range(0, 5) == 0);
        s.flush = ($urandom_range(0, 7) == 0);
        s.rst = ($urandom_range(0, 199) == 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst;
        io.id_valid = s.id_valid; io.id_pc = s.pc;
        io.id_rs1_idx = s.rs1; io.id_rs2_idx = s.rs2; io.id_rd_idx = s.rd;
        io.id_uses_rs1 = s.u1; io.id_uses_rs2 = s.u2;
        io.id_rs1_data = s.d1; io.id_rs2_data = s.d2; io.id_imm = s.imm;
        io.id_alu_sel = s.alu; io.id_a_sel = s.a_sel; io.id_b_sel = s.b_sel;
        io.id_reg_wen = s.wen; io.id_is_load = s.load;
        io.ex_alu_out = s.alu_out;
        io.wb_valid = s.wb_valid; io.wb_reg_wen = s.wb_wen;
        io.wb_rd_idx = s.wb_rd; io.wb_data = s.wb_data;
        io.ex_hold = s.hold; io.ex_flush = s.flush;
    endtask

    // Reference: which value would a reader of register idx see this cycle.
    function automatic logic [31:0] model_src(input logic [4:0] idx, input logic [31:0] rf, input stim_t s);
        if (idx == 5'd0) return rf;
        if (m.valid && m.wen && !m.load && m.rd == idx) return s.alu_out;
        if (s.wb_valid && s.wb_wen && s.wb_rd == idx) return s.wb_data;
        return rf;
    endfunction

    function automatic logic [EXP_W-1:0] pack_m(input mex_t x);
        return {x.pc, x.a, x.b, x.alu, x.rs2v, x.rd, x.wen, x.load};
    endfunction

    function automatic logic [EXP_W-1:0] pack_dut();
        return {io.ex_pc, io.ex_a_val, io.ex_b_val, io.ex_alu_sel, io.ex_rs2_val,
                io.ex_rd_idx, io.ex_reg_wen, io.ex_is_load};
    endfunction

    // One clock of stimulus; the model advances alongside and queues what EX must show next.
    task automatic cycle(input stim_t s);
        logic hz;
        logic [31:0] r1, r2;
        @(negedge clk);
        apply(s);
        #1;
        hz = s.id_valid && m.valid && m.load && m.wen && (m.rd != 5'd0) &&
             ((s.u1 && s.rs1 == m.rd) || (s.u2 && s.rs2 == m.rd));
        chk("id_ready", io.id_ready, !s.hold && !hz);
        r1 = model_src(s.rs1, s.d1, s);
        r2 = model_src(s.rs2, s.d2, s);
        if (s.rst) begin
            m = '{default: '0};
            m_cnt = 0;
        end else if (s.hold) begin
            m = m;
        end else if (s.flush) begin
            m.valid = 1'b0;
        end else if (hz) begin
            m.valid = 1'b0;
            if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
        end else if (s.id_valid) begin
            m.valid = 1'b1; m.pc = s.pc;
            m.a = s.a_sel ? s.pc : r1;
            m.b = s.b_sel ? s.imm : r2;
            m.alu = s.alu; m.rs2v = r2; m.rd = s.rd; m.wen = s.wen; m.load = s.load;
        end else begin
            m.valid = 1'b0;
        end
        stat_q.push_back({m.valid, CNT_W'(m_cnt)});
        if (m.valid) exp_q.push_back(pack_m(m));
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        post_edge();
        chk(name, {io.ex_valid, io.bubble_count, pack_dut()}, '0);
    endtask

    // Monitor: each falling edge compares what the last rising edge produced.
    initial begin
        logic [CNT_W:0] st;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                st = stat_q.pop_front();
                chk("ex_valid", io.ex_valid, st[CNT_W]);
                chk("bubble_count", io.bubble_count, st[CNT_W-1:0]);
                if (io.ex_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL ex_fields: got %0h expected none queued", pack_dut());
                    end else begin
                        chk("ex_fields", pack_dut(), exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        stim_t s, c, lw;
        n_checks = 0; n_errors = 0;
        m = '{default: '0}; m_cnt = 0;
        s = idle_stim(); s.rst = 1'b1;
        apply(s);
        cycle(s); cycle(s);
        check_zero("reset_state");

        // addi x1,x0,5 ; add x2,x1,x1 with EX forwarding
        s = mk(5'd1, 5'd0, 5'd0, 1, 0, A_SEL_RS1, B_SEL_IMM, 32'd5, 1, 0); s.d1 = 0;
        cycle(s);
        s = mk(5'd2, 5'd1, 5'd1, 1, 1, A_SEL_RS1, B_SEL_RS2, 32'd0, 1, 0); s.alu_out = 32'd5;
        cycle(s);
        post_edge();
        chk("ex_fwd_a", io.ex_a_val, 32'd5);
        chk("ex_fwd_b", io.ex_b_val, 32'd5);
        chk("no_bubble", io.bubble_count, 0);

        // lw x3 ; add x4,x3,x0 -> one bubble, retry picks WB data
        lw = mk(5'd3, 5'd0, 5'd0, 1, 0, A_SEL_RS1, B_SEL_IMM, 32'd4, 1, 1);
        cycle(lw);
        c = mk(5'd4, 5'd3, 5'd0, 1, 1, A_SEL_RS1, B_SEL_RS2, 32'd0, 1, 0); c.d2 = 0;
        cycle(c);
        post_edge();
        chk("bubble_valid", io.ex_valid, 0);
        chk("bubble_cnt1", io.bubble_count, 1);
        c.wb_valid = 1; c.wb_wen = 1; c.wb_rd = 5'd3; c.wb_data = 32'hDEAD_BEEF;
        cycle(c);
        post_edge();
        chk("retry_wb_a", io.ex_a_val, 32'hDEAD_BEEF);

        // EX and WB both write x5: EX wins
        cycle(mk(5'd5, 5'd0, 5'd0, 0, 0, A_SEL_PC, B_SEL_IMM, 32'd8, 1, 0));
        c = mk(5'd6, 5'd5, 5'd0, 1, 0, A_SEL_RS1, B_SEL_IMM, 32'd1, 1, 0);
        c.alu_out = 32'h11; c.wb_valid = 1; c.wb_wen = 1; c.wb_rd = 5'd5; c.wb_data = 32'h22;
        cycle(c);
        post_edge();
        chk("ex_over_wb", io.ex_a_val, 32'h11);

        // x0 is never forwarded
        cycle(mk(5'd0, 5'd1, 5'd0, 1, 0, A_SEL_RS1, B_SEL_IMM, 32'd3, 1, 0));
        c = mk(5'd7, 5'd0, 5'd0, 1, 0, A_SEL_RS1, B_SEL_IMM, 32'd2, 1, 0);
        c.d1 = 0; c.alu_out = 32'h1234; c.wb_valid = 1; c.wb_wen = 1; c.wb_rd = 0; c.wb_data = 32'h5555;
        cycle(c);
        post_edge();
        chk("x0_no_fwd", io.ex_a_val, 32'd0);

        // hold dominates flush; flush applies once hold drops
        cycle(mk(5'd8, 5'd2, 5'd1, 1, 1, A_SEL_RS1, B_SEL_RS2, 32'd0, 1, 0));
        c = mk(5'd9, 5'd1, 5'd2, 1, 1, A_SEL_RS1, B_SEL_RS2, 32'd0, 1, 0);
        c.hold = 1; c.flush = 1;
        repeat (3) cycle(c);
        post_edge();
        chk("hold_valid", io.ex_valid, 1);
        chk("hold_rd", io.ex_rd_idx, 5'd8);
        c.hold = 0;
        cycle(c);
        post_edge();
        chk("flush_valid", io.ex_valid, 0);

        // reach seven bubbles, then reset with a valid instruction in EX
        c = mk(5'd4, 5'd3, 5'd0, 1, 0, A_SEL_RS1, B_SEL_RS2, 32'd0, 1, 0);
        while (m_cnt < 7) begin
            cycle(lw);
            cycle(c);
        end
        cycle(mk(5'd10, 5'd0, 5'd0, 0, 0, A_SEL_PC, B_SEL_IMM, 32'd12, 1, 0));
        post_edge();
        chk("pre_rst_cnt", io.bubble_count, 7);
        chk("pre_rst_valid", io.ex_valid, 1);
        s = idle_stim(); s.rst = 1'b1;
        cycle(s);
        check_zero("mid_reset");

        // counter saturation
        repeat (20) begin
            cycle(lw);
            cycle(c);
        end
        post_edge();
        chk("cnt_saturate", io.bubble_count, (2 ** CNT_W) - 1);

        repeat (600) cycle(rand_stim());

        s = idle_stim();
        cycle(s); cycle(s);
        @(negedge clk);
        #2;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("stat_q_drained", stat_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
